// File: rtl/fifo_tx_banked.sv
// Multi-bank block-to-word TX FIFO: whole blocks load in one cycle, words drain one per handshake.
// Optional per-block send length is enabled by defining FIFO_TX_LEN_EN (adds the load_len port).
module fifo_tx_banked #(
    parameter int DATA_SIZE   = 8,
    parameter int BLOCK_WORDS = 16,
    parameter int NUM_BANKS   = 2
) (
    input  logic                                 clk_100MHz,
    input  logic                                 reset,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic [DATA_SIZE*BLOCK_WORDS-1:0]     load_data,
`ifdef FIFO_TX_LEN_EN
    input  logic [$clog2(BLOCK_WORDS):0]         load_len,
`endif
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic [DATA_SIZE-1:0]                 tx_data,
    output logic                                 tx_last,
    output logic                                 empty,
    output logic                                 full,
    output logic [$clog2(NUM_BANKS+1)-1:0]       banks_used,
    output logic                                 overflow
);

    localparam int BLOCK_BITS = DATA_SIZE * BLOCK_WORDS;
    localparam int IDX_W      = $clog2(BLOCK_WORDS);
    localparam int PTR_W      = $clog2(NUM_BANKS);
    localparam int CNT_W      = $clog2(NUM_BANKS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   wr_bank_reg, wr_bank_next;
    logic [PTR_W-1:0]   rd_bank_reg, rd_bank_next;
    logic [IDX_W-1:0]   rd_idx_reg, rd_idx_next;
    logic [CNT_W-1:0]   banks_used_reg, banks_used_next;
    logic               full_reg, full_next;
    logic               overflow_reg, overflow_next;

    logic [BLOCK_BITS-1:0] bank_mem [NUM_BANKS];
    logic [DATA_SIZE-1:0]  rd_words [BLOCK_WORDS];
    logic [IDX_W-1:0]      cur_last_idx;

    logic load_accept;
    logic pop;
    logic pop_last;

    // Handshake qualifiers; load_ready depends only on the registered full flag (no bypass).
    assign load_ready  = ~full_reg;
    assign load_accept = load_valid & ~full_reg;
    assign tx_valid    = (state_reg == SEND);
    assign pop         = tx_valid & tx_ready;
    assign tx_last     = tx_valid & (rd_idx_reg == cur_last_idx);
    assign pop_last    = pop & tx_last;

    assign empty       = (banks_used_reg == '0);
    assign full        = full_reg;
    assign banks_used  = banks_used_reg;
    assign overflow    = overflow_reg;

    // Block storage has no reset: contents survive reset and are simply overwritten by later loads.
    always_ff @(posedge clk_100MHz) begin
        if (load_accept) begin
            bank_mem[wr_bank_reg] <= load_data;
        end
    end

    generate
        for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word_unpack
            assign rd_words[gi] = bank_mem[rd_bank_reg][gi*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    assign tx_data = rd_words[rd_idx_reg];

`ifdef FIFO_TX_LEN_EN
    logic [IDX_W-1:0] last_mem [NUM_BANKS];
    logic [IDX_W-1:0] load_last_idx;

    // Out-of-range lengths (0 or larger than a block) fall back to a full block.
    always_comb begin
        load_last_idx = IDX_W'(BLOCK_WORDS - 1);
        if ((load_len != '0) && (load_len <= (IDX_W+1)'(BLOCK_WORDS))) begin
            load_last_idx = IDX_W'(load_len - 1'b1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (load_accept) begin
            last_mem[wr_bank_reg] <= load_last_idx;
        end
    end

    assign cur_last_idx = last_mem[rd_bank_reg];
`else
    assign cur_last_idx = IDX_W'(BLOCK_WORDS - 1);
`endif

    always_comb begin
        wr_bank_next    = wr_bank_reg;
        rd_bank_next    = rd_bank_reg;
        rd_idx_next     = rd_idx_reg;
        banks_used_next = banks_used_reg;
        overflow_next   = overflow_reg | (load_valid & full_reg);

        if (load_accept) begin
            wr_bank_next = wr_bank_reg + PTR_W'(1);
        end

        if (pop_last) begin
            rd_idx_next  = '0;
            rd_bank_next = rd_bank_reg + PTR_W'(1);
        end else if (pop) begin
            rd_idx_next = rd_idx_reg + IDX_W'(1);
        end

        case ({load_accept, pop_last})
            2'b10:   banks_used_next = banks_used_reg + CNT_W'(1);
            2'b01:   banks_used_next = banks_used_reg - CNT_W'(1);
            default: banks_used_next = banks_used_reg;
        endcase

        full_next = (banks_used_next == CNT_W'(NUM_BANKS));
    end

    // Drain FSM: SEND while any block is held.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load_accept) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (pop_last && (banks_used_reg == CNT_W'(1)) && !load_accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_bank_reg    <= '0;
            rd_bank_reg    <= '0;
            rd_idx_reg     <= '0;
            banks_used_reg <= '0;
            full_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_bank_reg    <= wr_bank_next;
            rd_bank_reg    <= rd_bank_next;
            rd_idx_reg     <= rd_idx_next;
            banks_used_reg <= banks_used_next;
            full_reg       <= full_next;
            overflow_reg   <= overflow_next;
        end
    end

endmodule

// File: tb/tb_fifo_tx_banked.sv
// Directed self-checking bench for fifo_tx_banked (default 8-bit words, 16-word blocks, 2 banks).
// Define FIFO_TX_LEN_EN for both bench and RTL to exercise the per-block length feature.
module tb_fifo_tx_banked;

    localparam int DATA_SIZE   = 8;
    localparam int BLOCK_WORDS = 16;
    localparam int NUM_BANKS   = 2;
    localparam int BLOCK_BITS  = DATA_SIZE * BLOCK_WORDS;

    logic                   clk_100MHz;
    logic                   reset;
    logic                   load_valid;
    logic                   load_ready;
    logic [BLOCK_BITS-1:0]  load_data;
`ifdef FIFO_TX_LEN_EN
    logic [4:0]             load_len;
`endif
    logic                   tx_valid;
    logic                   tx_ready;
    logic [DATA_SIZE-1:0]   tx_data;
    logic                   tx_last;
    logic                   empty;
    logic                   full;
    logic [1:0]             banks_used;
    logic                   overflow;

    int vectors;
    int miscompares;

    fifo_tx_banked #(
        .DATA_SIZE  (DATA_SIZE),
        .BLOCK_WORDS(BLOCK_WORDS),
        .NUM_BANKS  (NUM_BANKS)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
`ifdef FIFO_TX_LEN_EN
        .load_len  (load_len),
`endif
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .empty     (empty),
        .full      (full),
        .banks_used(banks_used),
        .overflow  (overflow)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    function automatic logic [BLOCK_BITS-1:0] mk_block(input logic [7:0] base);
        logic [BLOCK_BITS-1:0] blk;
        blk = '0;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            blk[k*DATA_SIZE +: DATA_SIZE] = base + 8'(k);
        end
        return blk;
    endfunction

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic load_block(input logic [7:0] base);
        load_valid = 1'b1;
        load_data  = mk_block(base);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
            chk({tag, "_data"},  32'(tx_data),  32'(base + 8'(k)));
            chk({tag, "_last"},  32'(tx_last),  32'(k == n - 1));
            $display("%s word %0d data=0x%02h last=%0d", tag, k, tx_data, tx_last);
            tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_data   = '0;
        tx_ready    = 1'b0;
`ifdef FIFO_TX_LEN_EN
        load_len    = 5'd16;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_empty",      32'(empty),      32'd1);
        chk("rst_full",       32'(full),       32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_tx_valid",   32'(tx_valid),   32'd0);
        chk("rst_tx_last",    32'(tx_last),    32'd0);
        chk("rst_overflow",   32'(overflow),   32'd0);
        chk("rst_banks_used", 32'(banks_used), 32'd0);

        // 1. Single block streams out on consecutive cycles
        tx_ready = 1'b1;
        load_block(8'h00);
        drain("t1", 8'h00, 16);
        chk("t1_empty_after", 32'(empty),    32'd1);
        chk("t1_valid_after", 32'(tx_valid), 32'd0);

        // 2. Backpressure holds word 0
        tx_ready = 1'b0;
        load_block(8'h00);
        for (int c = 0; c < 5; c++) begin
            chk("t2_hold_valid", 32'(tx_valid), 32'd1);
            chk("t2_hold_data",  32'(tx_data),  32'h00);
            $display("t2 hold cycle %0d data=0x%02h valid=%0d", c, tx_data, tx_valid);
            tick();
        end
        tx_ready = 1'b1;
        drain("t2", 8'h00, 16);

        // 3. Fill, overflow, drain in load order
        tx_ready = 1'b0;
        load_block(8'h40);
        chk("t3_used_a", 32'(banks_used), 32'd1);
        chk("t3_full_a", 32'(full),       32'd0);
        load_block(8'h80);
        chk("t3_used_b",  32'(banks_used), 32'd2);
        chk("t3_full_b",  32'(full),       32'd1);
        chk("t3_ready_b", 32'(load_ready), 32'd0);
        chk("t3_ovf_pre", 32'(overflow),   32'd0);
        load_block(8'hC0);
        chk("t3_ovf",    32'(overflow),   32'd1);
        chk("t3_used_c", 32'(banks_used), 32'd2);
        tx_ready = 1'b1;
        drain("t3a", 8'h40, 16);
        drain("t3b", 8'h80, 16);
        chk("t3_empty", 32'(empty), 32'd1);

        // 4. Load coincides with the last-word pop
        load_block(8'h10);
        for (int k = 0; k < 15; k++) begin
            chk("t4_pre_data", 32'(tx_data), 32'(8'h10 + 8'(k)));
            tick();
        end
        chk("t4_last",       32'(tx_last),    32'd1);
        chk("t4_last_data",  32'(tx_data),    32'h1F);
        chk("t4_used_pre",   32'(banks_used), 32'd1);
        load_block(8'h20);
        chk("t4_used_post",  32'(banks_used), 32'd1);
        drain("t4", 8'h20, 16);
        chk("t4_empty", 32'(empty), 32'd1);

        // 5. Asynchronous reset in the middle of a block
        load_block(8'h30);
        for (int k = 0; k < 7; k++) begin
            chk("t5_pre_data", 32'(tx_data), 32'(8'h30 + 8'(k)));
            tick();
        end
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(tx_valid),   32'd0);
        chk("t5_rst_used",  32'(banks_used), 32'd0);
        chk("t5_rst_empty", 32'(empty),      32'd1);
        chk("t5_rst_ovf",   32'(overflow),   32'd0);
        $display("t5 reset mid-stream valid=%0d banks_used=%0d", tx_valid, banks_used);
        tick();
        reset = 1'b0;
        load_block(8'h50);
        drain("t5", 8'h50, 16);
        chk("t5_empty", 32'(empty), 32'd1);

`ifdef FIFO_TX_LEN_EN
        // 6. Per-block length
        load_len = 5'd3;
        load_block(8'h60);
        drain("t6_len3", 8'h60, 3);
        chk("t6_len3_empty", 32'(empty), 32'd1);
        load_len = 5'd0;
        load_block(8'h70);
        drain("t6_len0", 8'h70, 16);
        chk("t6_len0_empty", 32'(empty), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
